// File: rtl/dual_branch_predictor.sv
// -----------------------------------------------------------------------------
// dual_branch_predictor
//
// Fetch-stage branch predictor for the dual-issue pipeline. It holds a bimodal
// table of 2-bit saturating counters, a direct-mapped tagged BTB and two
// saturating statistics counters. Lookups are combinational. Training happens
// on every rising edge from the outcomes resolved at M.
//
// Ports
//   clk                   rising-edge clock
//   rst                   asynchronous, active-low reset
//   PCF1 / PCF2           fetch PCs (slot 1 older, slot 2 younger)
//   PredictionF1 / F2     predicted taken, per slot
//   PredictedPCF1 / F2    predicted next PC, per slot
//   BranchM1 / M2         M-stage slot holds a conditional branch
//   PredictionM1 / M2     prediction that travelled with the branch
//   branch_taken1 / 2     resolved direction
//   PCM1 / PCM2           PC of the resolving branch
//   branchAdderResultM1/2 resolved branch target
//   BranchCount           resolved branches counted (saturating)
//   MispredictCount       mispredictions counted (saturating)
//
// M-stage inputs carry no valid/ready handshake. A slot is consumed on the
// edge where BranchM* is high, and the predictor can never stall it.
// -----------------------------------------------------------------------------
module dual_branch_predictor #(
  parameter int PC_WIDTH   = 8,
  parameter int INDEX_BITS = 4,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PC_WIDTH-1:0]   PCF1,
  input  logic [PC_WIDTH-1:0]   PCF2,
  output logic                  PredictionF1,
  output logic                  PredictionF2,
  output logic [PC_WIDTH-1:0]   PredictedPCF1,
  output logic [PC_WIDTH-1:0]   PredictedPCF2,
  input  logic                  BranchM1,
  input  logic                  BranchM2,
  input  logic                  PredictionM1,
  input  logic                  PredictionM2,
  input  logic                  branch_taken1,
  input  logic                  branch_taken2,
  input  logic [PC_WIDTH-1:0]   PCM1,
  input  logic [PC_WIDTH-1:0]   PCM2,
  input  logic [PC_WIDTH-1:0]   branchAdderResultM1,
  input  logic [PC_WIDTH-1:0]   branchAdderResultM2,
  output logic [STAT_WIDTH-1:0] BranchCount,
  output logic [STAT_WIDTH-1:0] MispredictCount
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = PC_WIDTH - INDEX_BITS;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]            cnt_q    [ENTRIES];
  logic [1:0]            cnt_d    [ENTRIES];
  logic [ENTRIES-1:0]    valid_q;
  logic [ENTRIES-1:0]    valid_d;
  logic [TAG_W-1:0]      tag_q    [ENTRIES];
  logic [PC_WIDTH-1:0]   target_q [ENTRIES];
  logic [STAT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
  logic [STAT_WIDTH-1:0] mis_cnt_q, mis_cnt_d;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic taken);
    logic [1:0] r;
    r = c;
    if (taken) begin
      if (c != 2'b11) r = c + 2'b01;
    end else begin
      if (c != 2'b00) r = c - 2'b01;
    end
    return r;
  endfunction

  // The increment is at most 2, so a carry out of the top bit is the only way
  // to pass all-ones. Clamping on that carry keeps the counter from wrapping.
  function automatic logic [STAT_WIDTH-1:0] sat_add(input logic [STAT_WIDTH-1:0] v,
                                                    input logic [1:0]            inc);
    logic [STAT_WIDTH:0] sum;
    sum = {1'b0, v} + {{(STAT_WIDTH-1){1'b0}}, inc};
    return sum[STAT_WIDTH] ? {STAT_WIDTH{1'b1}} : sum[STAT_WIDTH-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Lookup (combinational, reads pre-edge state; no write-to-read bypass)
  // ---------------------------------------------------------------------------
  logic [INDEX_BITS-1:0] idx_f1, idx_f2;
  logic                  hit_f1, hit_f2;
  logic                  taken_f1, taken_f2_raw;
  logic [PC_WIDTH-1:0]   seq_pc1, seq_pc2;

  assign idx_f1 = PCF1[INDEX_BITS-1:0];
  assign idx_f2 = PCF2[INDEX_BITS-1:0];

  assign hit_f1 = valid_q[idx_f1] && (tag_q[idx_f1] == PCF1[PC_WIDTH-1:INDEX_BITS]);
  assign hit_f2 = valid_q[idx_f2] && (tag_q[idx_f2] == PCF2[PC_WIDTH-1:INDEX_BITS]);

  assign taken_f1     = hit_f1 && cnt_q[idx_f1][1];
  assign taken_f2_raw = hit_f2 && cnt_q[idx_f2][1];

  // Sequential next PC wraps naturally at the PC width.
  assign seq_pc1 = PCF1 + PC_WIDTH'(1);
  assign seq_pc2 = PCF2 + PC_WIDTH'(1);

  assign PredictionF1  = taken_f1;
  assign PredictedPCF1 = taken_f1 ? target_q[idx_f1] : seq_pc1;

  // When slot 1 predicts taken, slot 2 sits on the not-fetched path, so its
  // own prediction is suppressed.
  assign PredictionF2  = taken_f2_raw && !taken_f1;
  assign PredictedPCF2 = (taken_f2_raw && !taken_f1) ? target_q[idx_f2] : seq_pc2;

  // ---------------------------------------------------------------------------
  // Resolution at M
  // ---------------------------------------------------------------------------
  logic [INDEX_BITS-1:0] idx_m1, idx_m2;
  logic                  mis1, mis2_eff;
  logic                  upd1, upd2;
  logic [1:0]            branch_inc, mis_inc;

  assign idx_m1 = PCM1[INDEX_BITS-1:0];
  assign idx_m2 = PCM2[INDEX_BITS-1:0];

  assign mis1 = BranchM1 && (PredictionM1 != branch_taken1);
  assign upd1 = BranchM1;
  // Slot 2 is wrong-path whenever slot 1 mispredicts: no training, no stats.
  assign upd2     = BranchM2 && !mis1;
  assign mis2_eff = upd2 && (PredictionM2 != branch_taken2);

  assign branch_inc = {1'b0, upd1} + {1'b0, upd2};
  assign mis_inc    = {1'b0, mis1} + {1'b0, mis2_eff};

  // ---------------------------------------------------------------------------
  // Next-state for counters and valid bits. Slot 1 is applied first, then
  // slot 2 on the result, so two updates to the same index chain correctly.
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (upd1) begin
      cnt_d[idx_m1] = sat_step(cnt_d[idx_m1], branch_taken1);
      if (branch_taken1) valid_d[idx_m1] = 1'b1;
    end
    if (upd2) begin
      cnt_d[idx_m2] = sat_step(cnt_d[idx_m2], branch_taken2);
      if (branch_taken2) valid_d[idx_m2] = 1'b1;
    end
  end

  always_comb begin
    branch_cnt_d = sat_add(branch_cnt_q, branch_inc);
    mis_cnt_d    = sat_add(mis_cnt_q, mis_inc);
  end

  // ---------------------------------------------------------------------------
  // Registers with reset
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_q[i] <= 2'b01;
      end
      valid_q      <= '0;
      branch_cnt_q <= '0;
      mis_cnt_q    <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      valid_q      <= valid_d;
      branch_cnt_q <= branch_cnt_d;
      mis_cnt_q    <= mis_cnt_d;
    end
  end

  // BTB tag/target storage carries no reset: entries are qualified by valid_q.
  // The slot 2 write comes second, so it wins when both slots write one index.
  always_ff @(posedge clk) begin
    if (upd1 && branch_taken1) begin
      tag_q[idx_m1]    <= PCM1[PC_WIDTH-1:INDEX_BITS];
      target_q[idx_m1] <= branchAdderResultM1;
    end
    if (upd2 && branch_taken2) begin
      tag_q[idx_m2]    <= PCM2[PC_WIDTH-1:INDEX_BITS];
      target_q[idx_m2] <= branchAdderResultM2;
    end
  end

  assign BranchCount     = branch_cnt_q;
  assign MispredictCount = mis_cnt_q;

endmodule

// File: tb/tb_dual_branch_predictor.sv
module tb_dual_branch_predictor;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] PCF1 = 8'h00, PCF2 = 8'h00;
  logic       PredictionF1, PredictionF2;
  logic [7:0] PredictedPCF1, PredictedPCF2;
  logic       BranchM1 = 0, BranchM2 = 0, PredictionM1 = 0, PredictionM2 = 0;
  logic       branch_taken1 = 0, branch_taken2 = 0;
  logic [7:0] PCM1 = 0, PCM2 = 0, branchAdderResultM1 = 0, branchAdderResultM2 = 0;
  logic [15:0] BranchCount, MispredictCount;

  always #5 clk = ~clk;

  dual_branch_predictor #(.PC_WIDTH(8), .INDEX_BITS(4), .STAT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .PCF1(PCF1), .PCF2(PCF2),
    .PredictionF1(PredictionF1), .PredictionF2(PredictionF2),
    .PredictedPCF1(PredictedPCF1), .PredictedPCF2(PredictedPCF2),
    .BranchM1(BranchM1), .BranchM2(BranchM2),
    .PredictionM1(PredictionM1), .PredictionM2(PredictionM2),
    .branch_taken1(branch_taken1), .branch_taken2(branch_taken2),
    .PCM1(PCM1), .PCM2(PCM2),
    .branchAdderResultM1(branchAdderResultM1), .branchAdderResultM2(branchAdderResultM2),
    .BranchCount(BranchCount), .MispredictCount(MispredictCount)
  );

  // ---------------------------------------------------------------------------
  // Reference model: plain integers, one record per table entry
  // ---------------------------------------------------------------------------
  int m_ctr [16];
  bit m_vld [16];
  int m_tag [16];
  int m_tgt [16];
  int m_branch, m_mis;

  int checks = 0;
  int failures = 0;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_ctr[i] = 1;
      m_vld[i] = 0;
      m_tag[i] = 0;
      m_tgt[i] = 0;
    end
    m_branch = 0;
    m_mis    = 0;
  endfunction

  function automatic bit model_taken(input int pc);
    int idx;
    idx = pc % 16;
    return m_vld[idx] && (m_tag[idx] == pc / 16) && (m_ctr[idx] >= 2);
  endfunction

  function automatic void model_train(input int pc, input bit taken, input int target);
    int idx;
    idx = pc % 16;
    if (taken) begin
      if (m_ctr[idx] < 3) m_ctr[idx]++;
      m_vld[idx] = 1;
      m_tag[idx] = pc / 16;
      m_tgt[idx] = target;
    end else begin
      if (m_ctr[idx] > 0) m_ctr[idx]--;
    end
  endfunction

  function automatic void model_update();
    bit mis1, upd1, upd2, mis2;
    mis1 = BranchM1 && (PredictionM1 != branch_taken1);
    upd1 = BranchM1;
    upd2 = BranchM2 && !mis1;
    mis2 = upd2 && (PredictionM2 != branch_taken2);
    if (upd1) model_train(int'(PCM1), branch_taken1, int'(branchAdderResultM1));
    if (upd2) model_train(int'(PCM2), branch_taken2, int'(branchAdderResultM2));
    m_branch = m_branch + int'(upd1) + int'(upd2);
    if (m_branch > 65535) m_branch = 65535;
    m_mis = m_mis + int'(mis1) + int'(mis2);
    if (m_mis > 65535) m_mis = 65535;
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit p1, p2;
    int n1, n2;
    p1 = model_taken(int'(PCF1));
    p2 = model_taken(int'(PCF2)) && !p1;
    n1 = p1 ? m_tgt[PCF1 % 16] : (int'(PCF1) + 1) % 256;
    n2 = p2 ? m_tgt[PCF2 % 16] : (int'(PCF2) + 1) % 256;
    chk("PredictionF1",    {31'd0, PredictionF1}, {31'd0, p1});
    chk("PredictionF2",    {31'd0, PredictionF2}, {31'd0, p2});
    chk("PredictedPCF1",   {24'd0, PredictedPCF1}, n1);
    chk("PredictedPCF2",   {24'd0, PredictedPCF2}, n2);
    chk("BranchCount",     {16'd0, BranchCount}, m_branch);
    chk("MispredictCount", {16'd0, MispredictCount}, m_mis);
  endtask

  // Called at a negedge with inputs already driven: check pre-edge outputs,
  // clock once, then advance the model.
  task automatic step(input bit do_check);
    #1;
    if (do_check) check_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_m1(input bit b, input bit p, input bit t, input logic [7:0] pc, input logic [7:0] tg);
    BranchM1 = b; PredictionM1 = p; branch_taken1 = t; PCM1 = pc; branchAdderResultM1 = tg;
  endtask

  task automatic set_m2(input bit b, input bit p, input bit t, input logic [7:0] pc, input logic [7:0] tg);
    BranchM2 = b; PredictionM2 = p; branch_taken2 = t; PCM2 = pc; branchAdderResultM2 = tg;
  endtask

  task automatic idle_m();
    set_m1(0, 0, 0, 8'h00, 8'h00);
    set_m2(0, 0, 0, 8'h00, 8'h00);
  endtask

  function automatic logic [7:0] rand_pc();
    // Few tags across all indices so both hits and aliasing occur often.
    return {4'($urandom_range(0, 2)), 4'($urandom_range(0, 15))};
  endfunction

  // ---------------------------------------------------------------------------
  // Directed + randomized sequence
  // ---------------------------------------------------------------------------
  initial begin
    model_reset();
    rst = 1'b0;
    PCF1 = 8'h10; PCF2 = 8'h11;
    #13;
    // Under reset: predictions combinational, counters at zero.
    chk("reset_PredF1", {31'd0, PredictionF1}, 32'd0);
    chk("reset_PredF2", {31'd0, PredictionF2}, 32'd0);
    chk("reset_PPC1", {24'd0, PredictedPCF1}, 32'h11);
    chk("reset_PPC2", {24'd0, PredictedPCF2}, 32'h12);
    chk("reset_BranchCount", {16'd0, BranchCount}, 32'd0);
    chk("reset_MispredictCount", {16'd0, MispredictCount}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Train entry 3 taken twice with a not-taken prediction -> two mispredicts.
    set_m1(1, 0, 1, 8'h13, 8'h40);
    step(1);
    step(1);
    idle_m();
    PCF1 = 8'h13; PCF2 = 8'h30;
    step(1);
    chk("trained_PredF1", {31'd0, PredictionF1}, 32'd1);
    chk("trained_PPC1", {24'd0, PredictedPCF1}, 32'h40);
    chk("trained_BranchCount", {16'd0, BranchCount}, 32'd2);
    chk("trained_MispredictCount", {16'd0, MispredictCount}, 32'd2);

    // Aliasing: same index, different tag.
    PCF1 = 8'h23;
    step(1);
    chk("alias_PredF1", {31'd0, PredictionF1}, 32'd0);
    chk("alias_PPC1", {24'd0, PredictedPCF1}, 32'h24);

    // Same-index dual update: slot 1 mispredicts, slot 2 is dropped.
    set_m1(1, 1, 0, 8'h13, 8'h55);
    set_m2(1, 1, 1, 8'h13, 8'h66);
    step(1);
    idle_m();
    PCF1 = 8'h13;
    step(1);
    chk("dual_PredF1_ctr10", {31'd0, PredictionF1}, 32'd1);
    chk("dual_PPC1_keeps_target", {24'd0, PredictedPCF1}, 32'h40);
    chk("dual_BranchCount", {16'd0, BranchCount}, 32'd3);
    chk("dual_MispredictCount", {16'd0, MispredictCount}, 32'd3);

    // Train entry 4 taken, then exercise the slot-2 shadow.
    set_m1(1, 1, 1, 8'h14, 8'h50);
    step(1);
    step(1);
    idle_m();
    PCF1 = 8'h13; PCF2 = 8'h14;
    step(1);
    chk("shadow_PredF2", {31'd0, PredictionF2}, 32'd0);
    chk("shadow_PPC2", {24'd0, PredictedPCF2}, 32'h15);
    PCF1 = 8'h20;
    step(1);
    chk("noshadow_PredF2", {31'd0, PredictionF2}, 32'd1);
    chk("noshadow_PPC2", {24'd0, PredictedPCF2}, 32'h50);

    // Wrap of the sequential PC.
    PCF1 = 8'h20; PCF2 = 8'hFF;
    step(1);
    chk("wrap_PPC2", {24'd0, PredictedPCF2}, 32'h00);

    // Non-branch M slots must not change anything.
    set_m1(0, 0, 1, 8'h13, 8'h99);
    set_m2(0, 1, 0, 8'h14, 8'h88);
    PCF1 = 8'h13; PCF2 = 8'h14;
    step(1);
    step(1);

    // Randomized training and lookup against the model.
    for (int n = 0; n < 400; n++) begin
      PCF1 = rand_pc(); PCF2 = rand_pc();
      set_m1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             rand_pc(), 8'($urandom));
      set_m2(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             rand_pc(), 8'($urandom));
      step(1);
    end
    idle_m();
    step(1);

    // Saturation: drive dual branches until BranchCount reaches 16'hFFFE.
    if (m_branch % 2 == 1) begin
      set_m1(1, 1, 1, 8'h05, 8'h77);
      step(0);
    end
    set_m1(1, 1, 1, 8'h05, 8'h77);
    set_m2(1, 0, 1, 8'h06, 8'h78);
    while (m_branch < 65534) step(0);
    idle_m();
    step(1);
    chk("sat_pre_BranchCount", {16'd0, BranchCount}, 32'hFFFE);
    set_m1(1, 1, 1, 8'h05, 8'h77);
    set_m2(1, 1, 1, 8'h06, 8'h78);
    step(1);
    step(1);
    chk("sat_BranchCount", {16'd0, BranchCount}, 32'hFFFF);
    idle_m();
    step(1);

    // Asynchronous reset in the middle of a burst of updates.
    for (int n = 0; n < 6; n++) begin
      set_m1(1, 0, 1, 8'h13, 8'h40);
      set_m2(1, 1, 1, 8'h14, 8'h50);
      step(1);
    end
    PCF1 = 8'h13; PCF2 = 8'h20;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("async_rst_BranchCount", {16'd0, BranchCount}, 32'd0);
    chk("async_rst_MispredictCount", {16'd0, MispredictCount}, 32'd0);
    chk("async_rst_PredF1", {31'd0, PredictionF1}, 32'd0);
    chk("async_rst_PPC1", {24'd0, PredictedPCF1}, 32'h14);
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b1;
    set_m1(1, 0, 1, 8'h13, 8'h40);
    idle_m();
    set_m1(1, 0, 1, 8'h13, 8'h40);
    step(1);
    idle_m();
    step(1);
    chk("post_rst_BranchCount", {16'd0, BranchCount}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dual_branch_predictor.md
Name: dual_branch_predictor

Overview:
- Fetch-stage branch predictor for the dual-issue pipeline. It produces the per-slot taken prediction and predicted next PC that travel down the pipe and return at M as PredictionM1/PredictionM2.
- Trained every cycle from the resolved outcomes at M, which are the same signals the PC-correction logic consumes.
- Contains a bimodal table of 2-bit saturating counters, a direct-mapped tagged BTB, and saturating branch/mispredict statistics counters.

Parameters:
- PC_WIDTH, 8, PC/address width.
- INDEX_BITS, 4, log2 of table entries (16 entries); index = PC[INDEX_BITS-1:0].
- STAT_WIDTH, 16, width of statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- PCF1  in  PC_WIDTH  fetch PC, slot 1 (older).
- PCF2  in  PC_WIDTH  fetch PC, slot 2 (younger).
- PredictionF1  out  1  slot 1 predicted taken.
- PredictionF2  out  1  slot 2 predicted taken.
- PredictedPCF1  out  PC_WIDTH  predicted next PC for slot 1.
- PredictedPCF2  out  PC_WIDTH  predicted next PC for slot 2.
- BranchM1, BranchM2  in  1  M-stage slot holds a conditional branch.
- PredictionM1, PredictionM2  in  1  prediction carried with the branch.
- branch_taken1, branch_taken2  in  1  resolved direction.
- PCM1, PCM2  in  PC_WIDTH  PC of the resolving branch.
- branchAdderResultM1, branchAdderResultM2  in  PC_WIDTH  resolved target.
- BranchCount  out  STAT_WIDTH  resolved branches counted.
- MispredictCount  out  STAT_WIDTH  mispredictions counted.

Behaviour:
- Reset (rst=0, async):
  - All counters are set to 2'b01 (weakly not-taken).
  - All BTB valid bits are cleared; tags and targets are don't-care.
  - BranchCount and MispredictCount are set to 0.
  - Prediction outputs are combinational, so under reset they read PredictionF*=0 and PredictedPCF*=PCF*+1.
- Lookup (combinational, zero latency):
  - hit = valid[idx] & (tag[idx] == PC[PC_WIDTH-1:INDEX_BITS]).
  - PredictionF = hit & counter[idx][1].
  - PredictedPCF = PredictionF ? target[idx] : PC+1, with the +1 wrapping mod 2^PC_WIDTH (8'hFF -> 8'h00).
  - Lookups read pre-edge state; there is no write-to-read bypass in the same cycle.
- Slot-2 shadow: if PredictionF1=1, force PredictionF2=0 and PredictedPCF2=PCF2+1, because slot 2 is on the predicted-not-fetched path.
- Misprediction: Mis1 = BranchM1 & (PredictionM1 != branch_taken1); Mis2 is defined the same way for slot 2.
- Update enables:
  - Upd1 = BranchM1.
  - Upd2 = BranchM2 & ~Mis1, since slot 2 is wrong-path when slot 1 mispredicts. Mis2 is likewise ignored when Mis1=1.
- Counter update on the rising edge:
  - Taken increments, saturating at 2'b11.
  - Not-taken decrements, saturating at 2'b00.
  - If Upd1 and Upd2 hit the same index, apply slot 1 then slot 2 to the same entry. Example: 01 with T,T -> 11; 11 with T,N -> 10.
- BTB update:
  - On an update with taken=1, write valid=1, tag and target=branchAdderResultM*.
  - If both slots write the same index, slot 2 wins.
  - A not-taken outcome never invalidates an entry.
- Statistics:
  - BranchCount += Upd1 + Upd2 (0..2 per cycle).
  - MispredictCount += Mis1 + (Upd2 & Mis2).
  - Both saturate at all-ones. An increment of 2 from all-ones minus 1 yields all-ones; neither counter ever wraps.
- Reset asserted mid-operation clears state immediately, regardless of pending updates. The first update after deassertion is taken on the next rising edge.
- Non-branch M slots (BranchM*=0) cause no table or statistics change, whatever the taken/prediction inputs are.

Test Plan:
- Reset, then PCF1=8'h10, PCF2=8'h11 -> PredictionF1=PredictionF2=0, PredictedPCF1=8'h11, PredictedPCF2=8'h12, both stat counters 0.
- Two cycles with BranchM1=1, PCM1=8'h13, taken=1, target=8'h40, PredictionM1=0 -> counter[3]=11, BTB hit. Then PCF1=8'h13 -> PredictionF1=1, PredictedPCF1=8'h40. BranchCount=2, MispredictCount=2.
- Aliasing: with entry 3 trained as above, PCF1=8'h23 (tag mismatch) -> PredictionF1=0, PredictedPCF1=8'h24.
- Same-index dual update from counter 11: slot 1 N, slot 2 T, both at index 3 with PredictionM=1 -> Mis1=1, Upd2 suppressed, counter=10, BranchCount +1, MispredictCount +1.
- Shadow and wrap:
  - With PCF1 predicted taken and PCF2's entry also trained taken -> PredictionF2=0.
  - With PCF2=8'hFF not taken -> PredictedPCF2=8'h00.
- Saturation and reset:
  - Preload stats to 16'hFFFE, two correct branches in one cycle -> BranchCount=16'hFFFF, which then holds.
  - Pull rst low mid-burst -> all state returns to reset values asynchronously.
